fifo_sc_v2: RTL and testbench

//  Single-clock, parametrised synchronous FIFO. Successor to the lab FIFO: power-of-2 depth,

---
 rtl/fifo_pkg.sv | 28 ++
 rtl/fifo_sc_v2_if.sv | 31 +++
 rtl/fifo_dp_ram.sv | 32 +++
 rtl/fifo_sc_v2.sv | 157 +++++++++++++++
 tb/tb_fifo_sc_v2.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the fifo_sc_v2 elastic buffer.
package fifo_pkg;

    typedef struct packed {
        logic empty;
        logic full;
        logic almost_empty;
        logic almost_full;
        logic overflow;
        logic underflow;
    } fifo_status_t;

    function automatic int fifo_depth(input int aw);
        return 1 << aw;
    endfunction

    // Modular pointer distance, masked to pw bits.
    function automatic logic [31:0] ptr_diff(
        input logic [31:0] a,
        input logic [31:0] b,
        input int          pw
    );
        logic [31:0] m;
        m = (32'd1 << pw) - 32'd1;
        return (a - b) & m;
    endfunction

endpackage

// File: rtl/fifo_sc_v2_if.sv
// Write/read/status bundle of fifo_sc_v2; slave is the FIFO side.
interface fifo_sc_v2_if #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 4
);
    logic              flush_i;
    logic              clr_err_i;
    logic [DWIDTH-1:0] data_i;
    logic              wrreq_i;
    logic              rdreq_i;
    logic [DWIDTH-1:0] q_o;
    logic              empty_o;
    logic              full_o;
    logic [AWIDTH:0]   usedw_o;
    logic              almost_full_o;
    logic              almost_empty_o;
    logic              overflow_o;
    logic              underflow_o;

    modport master (
        output flush_i, clr_err_i, data_i, wrreq_i, rdreq_i,
        input  q_o, empty_o, full_o, usedw_o, almost_full_o,
        input  almost_empty_o, overflow_o, underflow_o
    );

    modport slave (
        input  flush_i, clr_err_i, data_i, wrreq_i, rdreq_i,
        output q_o, empty_o, full_o, usedw_o, almost_full_o,
        output almost_empty_o, overflow_o, underflow_o
    );
endinterface

// File: rtl/fifo_dp_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
module fifo_dp_ram
    import fifo_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 4
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              clr,
    input  logic              we,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic              re,
    input  logic [AWIDTH-1:0] raddr,
    output logic [DWIDTH-1:0] q
);
    localparam int DEPTH = fifo_depth(AWIDTH);

    logic [DWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we) mem[waddr] <= wdata;
    end

    // Output register is cleared so the FIFO data port reads 0 after flush.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i)  q <= '0;
        else if (clr)   q <= '0;
        else if (re)    q <= mem[raddr];
    end
endmodule

// File: rtl/fifo_sc_v2.sv
// Single-clock FIFO: showahead or normal read, optional output stage, sticky errors.
module fifo_sc_v2
    import fifo_pkg::*;
#(
    parameter int DWIDTH             = 8,
    parameter int AWIDTH             = 4,
    parameter int SHOWAHEAD          = 1,
    parameter int REGISTER_OUTPUT    = 0,
    parameter int ALMOST_FULL_VALUE  = 12,
    parameter int ALMOST_EMPTY_VALUE = 2
) (
    input logic         clk_i,
    input logic         arst_n_i,
    fifo_sc_v2_if.slave bus
);
    localparam int PW = AWIDTH + 1;

    logic [PW-1:0]     wr_ptr, rd_ptr, usedw;
    logic              full, empty, wr_acc, rd_acc;
    logic              ram_re;
    logic [AWIDTH-1:0] ram_raddr;
    logic [DWIDTH-1:0] ram_q, q;
    logic              ovf, udf;
    fifo_status_t      st;

    assign usedw  = PW'(ptr_diff(32'(wr_ptr), 32'(rd_ptr), PW));
    assign full   = (wr_ptr[AWIDTH] != rd_ptr[AWIDTH]) &&
                    (wr_ptr[AWIDTH-1:0] == rd_ptr[AWIDTH-1:0]);
    assign wr_acc = bus.wrreq_i && !full && !bus.flush_i;
    assign rd_acc = bus.rdreq_i && !empty && !bus.flush_i;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (bus.flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
            if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // A new error in the same cycle as clr_err_i wins.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            ovf <= (bus.wrreq_i && full && !bus.flush_i) ||
                   (ovf && !bus.clr_err_i);
            udf <= (bus.rdreq_i && empty && !bus.flush_i) ||
                   (udf && !bus.clr_err_i);
        end
    end

    fifo_dp_ram #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) u_ram (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .clr      (bus.flush_i),
        .we       (wr_acc),
        .waddr    (wr_ptr[AWIDTH-1:0]),
        .wdata    (bus.data_i),
        .re       (ram_re),
        .raddr    (ram_raddr),
        .q        (ram_q)
    );

    if (SHOWAHEAD != 0) begin : g_sa
        // RAM output register doubles as the prefetch (head) register.
        logic pf_vld;

        always_comb begin
            ram_re    = 1'b0;
            ram_raddr = rd_ptr[AWIDTH-1:0];
            if (bus.flush_i) begin
                ram_re = 1'b0;
            end else if (!pf_vld && usedw != '0) begin
                ram_re = 1'b1;
            end else if (rd_acc && usedw > PW'(1)) begin
                ram_re    = 1'b1;
                ram_raddr = rd_ptr[AWIDTH-1:0] + AWIDTH'(1);
            end
        end

        always_ff @(posedge clk_i or negedge arst_n_i) begin
            if (!arst_n_i)        pf_vld <= 1'b0;
            else if (bus.flush_i) pf_vld <= 1'b0;
            else if (ram_re)      pf_vld <= 1'b1;
            else if (rd_acc)      pf_vld <= 1'b0;
        end

        assign empty = !pf_vld;
        assign q     = ram_q;
    end else begin : g_nm
        logic              v1;
        logic [DWIDTH-1:0] q1;

        assign ram_re    = rd_acc;
        assign ram_raddr = rd_ptr[AWIDTH-1:0];
        assign empty     = (usedw == '0);

        always_ff @(posedge clk_i or negedge arst_n_i) begin
            if (!arst_n_i) begin
                v1 <= 1'b0;
                q1 <= '0;
            end else if (bus.flush_i) begin
                v1 <= 1'b0;
                q1 <= '0;
            end else begin
                v1 <= rd_acc;
                if (v1) q1 <= ram_q;
            end
        end

        if (REGISTER_OUTPUT != 0) begin : g_oreg
            logic              v2;
            logic [DWIDTH-1:0] q2;

            always_ff @(posedge clk_i or negedge arst_n_i) begin
                if (!arst_n_i) begin
                    v2 <= 1'b0;
                    q2 <= '0;
                end else if (bus.flush_i) begin
                    v2 <= 1'b0;
                    q2 <= '0;
                end else begin
                    v2 <= v1;
                    if (v2) q2 <= q1;
                end
            end

            assign q = q2;
        end else begin : g_odir
            assign q = q1;
        end
    end

    always_comb begin
        st.empty        = empty;
        st.full         = full;
        st.almost_empty = usedw < PW'(ALMOST_EMPTY_VALUE);
        st.almost_full  = usedw >= PW'(ALMOST_FULL_VALUE);
        st.overflow     = ovf;
        st.underflow    = udf;
    end

    assign bus.q_o            = q;
    assign bus.usedw_o        = usedw;
    assign bus.empty_o        = st.empty;
    assign bus.full_o         = st.full;
    assign bus.almost_empty_o = st.almost_empty;
    assign bus.almost_full_o  = st.almost_full;
    assign bus.overflow_o     = st.overflow;
    assign bus.underflow_o    = st.underflow;
endmodule

// File: tb/tb_fifo_sc_v2.sv
// Bench for fifo_sc_v2: showahead instance (defaults) and normal+output-register instance.
module tb_fifo_sc_v2;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    fifo_sc_v2_if #(.DWIDTH(8), .AWIDTH(4)) ia ();
    fifo_sc_v2_if #(.DWIDTH(8), .AWIDTH(4)) ib ();

    fifo_sc_v2 u_a (
        .clk_i    (clk),
        .arst_n_i (rst_n),
        .bus      (ia)
    );

    fifo_sc_v2 #(.SHOWAHEAD(0), .REGISTER_OUTPUT(1)) u_b (
        .clk_i    (clk),
        .arst_n_i (rst_n),
        .bus      (ib)
    );

    typedef struct {
        bit         wr;
        bit         clr;
        logic [7:0] d;
        int         usedw;
        bit         empty;
        bit         full;
        bit         afull;
        bit         ovf;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    int         cnt;
    bit         pf, ovf_m, udf_m, last_wacc;
    int         popped;
    logic [7:0] sb[$];
    vec_t       vt[18];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One cycle on the showahead instance with a reference model of it.
    task automatic cyc_a(input bit wr, input bit rd, input logic [7:0] d,
                         input bit fl = 1'b0, input bit clr = 1'b0);
        bit wacc, racc, pf_n;
        ia.wrreq_i   = wr;
        ia.rdreq_i   = rd;
        ia.data_i    = d;
        ia.flush_i   = fl;
        ia.clr_err_i = clr;
        wacc = !fl && wr && cnt < 16;
        racc = !fl && rd && pf;
        if (racc) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sa_rd: read accepted with empty scoreboard");
            end else begin
                chk("sa_rd", 32'(ia.q_o), 32'(sb.pop_front()));
                popped++;
            end
        end
        ovf_m = (!fl && wr && cnt == 16) || (ovf_m && !clr);
        udf_m = (!fl && rd && !pf) || (udf_m && !clr);
        if (fl)                pf_n = 1'b0;
        else if (!pf && cnt > 0) pf_n = 1'b1;
        else if (racc)         pf_n = (cnt > 1);
        else                   pf_n = pf;
        pf = pf_n;
        if (fl) begin
            cnt = 0;
            sb.delete();
        end else begin
            if (wacc) sb.push_back(d);
            cnt = cnt + int'(wacc) - int'(racc);
        end
        last_wacc = wacc;
        step();
        chk("sa_usedw", 32'(ia.usedw_o), 32'(cnt));
        chk("sa_empty", 32'(ia.empty_o), 32'(!pf));
        chk("sa_full", 32'(ia.full_o), 32'(cnt == 16));
        chk("sa_afull", 32'(ia.almost_full_o), 32'(cnt >= 12));
        chk("sa_aempty", 32'(ia.almost_empty_o), 32'(cnt < 2));
        chk("sa_ovf", 32'(ia.overflow_o), 32'(ovf_m));
        chk("sa_udf", 32'(ia.underflow_o), 32'(udf_m));
    endtask

    task automatic drain_a();
        for (int k = 0; k < 64 && cnt > 0; k++) cyc_a(1'b0, pf, 8'h00);
    endtask

    task automatic model_reset();
        cnt = 0;
        pf = 1'b0;
        ovf_m = 1'b0;
        udf_m = 1'b0;
        popped = 0;
        sb.delete();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_usedw"}, 32'(ia.usedw_o), 32'd0);
        chk({tag, "_empty"}, 32'(ia.empty_o), 32'd1);
        chk({tag, "_aempty"}, 32'(ia.almost_empty_o), 32'd1);
        chk({tag, "_full"}, 32'(ia.full_o), 32'd0);
        chk({tag, "_afull"}, 32'(ia.almost_full_o), 32'd0);
        chk({tag, "_ovf"}, 32'(ia.overflow_o), 32'd0);
        chk({tag, "_udf"}, 32'(ia.underflow_o), 32'd0);
        chk({tag, "_q"}, 32'(ia.q_o), 32'd0);
        chk({tag, "_b_q"}, 32'(ib.q_o), 32'd0);
        chk({tag, "_b_udf"}, 32'(ib.underflow_o), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  nxt;
        bit  w, r;

        rst_n = 1'b0;
        {ia.wrreq_i, ia.rdreq_i, ia.flush_i, ia.clr_err_i} = '0;
        {ib.wrreq_i, ib.rdreq_i, ib.flush_i, ib.clr_err_i} = '0;
        ia.data_i = '0;
        ib.data_i = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset("rst");
        rst_n = 1'b1;
        step();

        // Fill to full, one rejected write, then clear the error.
        for (int i = 0; i < 16; i++)
            vt[i] = '{1'b1, 1'b0, 8'(16 + i), i + 1, i == 0, i == 15,
                      (i + 1) >= 12, 1'b0};
        vt[16] = '{1'b1, 1'b0, 8'hEE, 16, 1'b0, 1'b1, 1'b1, 1'b1};
        vt[17] = '{1'b0, 1'b1, 8'h00, 16, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 18; i++) begin
            cyc_a(vt[i].wr, 1'b0, vt[i].d, 1'b0, vt[i].clr);
            chk($sformatf("t1_usedw_%0d", i), 32'(ia.usedw_o), 32'(vt[i].usedw));
            chk($sformatf("t1_empty_%0d", i), 32'(ia.empty_o), 32'(vt[i].empty));
            chk($sformatf("t1_full_%0d", i), 32'(ia.full_o), 32'(vt[i].full));
            chk($sformatf("t1_afull_%0d", i), 32'(ia.almost_full_o), 32'(vt[i].afull));
            chk($sformatf("t1_ovf_%0d", i), 32'(ia.overflow_o), 32'(vt[i].ovf));
        end
        chk("t1_head", 32'(ia.q_o), 32'h10);
        drain_a();

        // Showahead fall-through of a single word, then underflow.
        cyc_a(1'b1, 1'b0, 8'hA5);
        chk("t2_empty_n", 32'(ia.empty_o), 32'd1);
        cyc_a(1'b0, 1'b0, 8'h00);
        chk("t2_empty_n1", 32'(ia.empty_o), 32'd0);
        chk("t2_q", 32'(ia.q_o), 32'hA5);
        cyc_a(1'b0, 1'b1, 8'h00);
        chk("t2_empty_rd", 32'(ia.empty_o), 32'd1);
        chk("t2_usedw", 32'(ia.usedw_o), 32'd0);
        cyc_a(1'b0, 1'b1, 8'h00);
        chk("t2_udf", 32'(ia.underflow_o), 32'd1);
        cyc_a(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("t2_udf_clr", 32'(ia.underflow_o), 32'd0);

        // Normal mode with output register: two-plus-one cycle read latency.
        ib.data_i = 8'h11;
        ib.wrreq_i = 1'b1;
        step();
        chk("t3_empty", 32'(ib.empty_o), 32'd0);
        ib.data_i = 8'h22;
        step();
        ib.wrreq_i = 1'b0;
        step();
        chk("t3_usedw", 32'(ib.usedw_o), 32'd2);
        ib.rdreq_i = 1'b1;
        step();
        chk("t3_q_m", 32'(ib.q_o), 32'd0);
        step();
        ib.rdreq_i = 1'b0;
        chk("t3_q_m1", 32'(ib.q_o), 32'd0);
        chk("t3_empty2", 32'(ib.empty_o), 32'd1);
        step();
        chk("t3_q_m2", 32'(ib.q_o), 32'h11);
        step();
        chk("t3_q_m3", 32'(ib.q_o), 32'h22);
        step();
        chk("t3_q_hold", 32'(ib.q_o), 32'h22);
        ib.rdreq_i = 1'b1;
        step();
        ib.rdreq_i = 1'b0;
        chk("t3_udf", 32'(ib.underflow_o), 32'd1);
        chk("t3_usedw0", 32'(ib.usedw_o), 32'd0);

        // Full with simultaneous read/write, then half-full streaming.
        for (int i = 0; i < 16; i++) cyc_a(1'b1, 1'b0, 8'(i));
        cyc_a(1'b1, 1'b1, 8'h77);
        chk("t4_usedw", 32'(ia.usedw_o), 32'd15);
        chk("t4_ovf", 32'(ia.overflow_o), 32'd1);
        chk("t4_full", 32'(ia.full_o), 32'd0);
        cyc_a(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        for (int k = 0; k < 16 && cnt > 8; k++) cyc_a(1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 40; i++) begin
            cyc_a(1'b1, 1'b1, 8'h80 + 8'(i));
            chk("t4_const", 32'(ia.usedw_o), 32'd8);
        end
        drain_a();

        // Wrap: 100 incrementing words with random gaps.
        popped = 0;
        nxt = 0;
        for (int k = 0; k < 3000 && popped < 100; k++) begin
            w = (nxt < 100) && ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) != 0);
            cyc_a(w, r, 8'(nxt));
            if (last_wacc) nxt++;
        end
        if (popped != 100) begin
            checks++;
            errors++;
            $display("FAIL t5_count: popped %0d words, required 100", popped);
        end

        // Flush with flags held, then asynchronous reset mid-stream.
        cyc_a(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        cyc_a(1'b0, 1'b1, 8'h00);
        chk("t6_udf_set", 32'(ia.underflow_o), 32'd1);
        for (int i = 0; i < 7; i++) cyc_a(1'b1, 1'b0, 8'hC0 + 8'(i));
        chk("t6_usedw7", 32'(ia.usedw_o), 32'd7);
        cyc_a(1'b1, 1'b1, 8'hFF, 1'b1, 1'b0);
        chk("t6_empty", 32'(ia.empty_o), 32'd1);
        chk("t6_usedw", 32'(ia.usedw_o), 32'd0);
        chk("t6_q", 32'(ia.q_o), 32'd0);
        chk("t6_udf_kept", 32'(ia.underflow_o), 32'd1);
        chk("t6_ovf", 32'(ia.overflow_o), 32'd0);
        for (int i = 0; i < 3; i++) cyc_a(1'b1, 1'b0, 8'(i + 1));
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset("t6_arst");
        model_reset();
        {ia.wrreq_i, ia.rdreq_i, ia.flush_i, ia.clr_err_i} = '0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        step();
        cyc_a(1'b1, 1'b0, 8'h5A);
        cyc_a(1'b0, 1'b0, 8'h00);
        cyc_a(1'b0, 1'b1, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
